// File: rtl/spin_accumulator.sv
// spin_accumulator: turns digital left/right, fast and HPS spinner deltas into an 8-bit dial position.
// Ports: clk, reset (sync, active-high), minus, plus, fast, strobe (rising edge paces digital motion),
//        spin_in[8] event toggle + spin_in[7:0] signed delta, spin_out 8-bit wrapping dial position.
// Optional: SPIN_SMOOTH_EN buffers analog deltas in a saturating pending register that drains per strobe.
module spin_accumulator #(
  parameter int STEP_MIN = 1,
  parameter int STEP_MAX = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       minus,
  input  logic       plus,
  input  logic       fast,
  input  logic       strobe,
  input  logic [8:0] spin_in,
  output logic [7:0] spin_out
);
  localparam logic [7:0] SMIN = 8'(STEP_MIN);
  localparam logic [7:0] SMAX = 8'(STEP_MAX);
  localparam logic [31:0] AF = 32'(ACCEL_FRAMES);
  logic [7:0] speed, speed_nx, spd_base, mag, dstep, adv;
  logic [31:0] cnt, cnt_nx, cnt_base, cnt_inc;
  logic [1:0] dir, last_dir;
  logic strobe_d, tog_d, se, ev, same, wrap;
  always_comb begin
    se = strobe & ~strobe_d;
    ev = spin_in[8] ^ tog_d;
    // dir[0] = toward higher position, dir[1] = toward lower; 00 = none
    dir = {minus & ~plus, plus & ~minus};
    same = dir == last_dir;
    // a start or reversal restarts the ramp from STEP_MIN before stepping
    spd_base = same ? speed : SMIN;
    cnt_base = same ? cnt : 32'd0;
    cnt_inc = cnt_base + 32'd1;
    wrap = cnt_inc == AF;
    speed_nx = dir == 2'b00 ? SMIN : wrap ? (spd_base >= SMAX ? SMAX : spd_base + 8'd1) : spd_base;
    cnt_nx = (dir == 2'b00 || wrap) ? 32'd0 : cnt_inc;
    mag = fast ? {spd_base[6:0], 1'b0} : spd_base;
    dstep = !se ? 8'd0 : dir == 2'b01 ? mag : dir == 2'b10 ? 8'd0 - mag : 8'd0;
  end
`ifdef SPIN_SMOOTH_EN
  localparam logic signed [9:0] PMAX = 10'(STEP_MAX);
  logic signed [9:0] pend, drain, pend_left, pend_nx;
  logic signed [10:0] sum;
  always_comb begin
    // drain uses the pending value from before this cycle's event is added
    drain = !se ? 10'sd0 : pend > PMAX ? PMAX : pend < -PMAX ? -PMAX : pend;
    pend_left = pend - drain;
    sum = {pend_left[9], pend_left} + (ev ? {{3{spin_in[7]}}, spin_in[7:0]} : 11'd0);
    pend_nx = sum > 11'sd511 ? 10'sd511 : sum < -11'sd512 ? -10'sd512 : sum[9:0];
    adv = drain[7:0];
  end
  always_ff @(posedge clk)
    pend <= reset ? 10'sd0 : pend_nx;
`else
  always_comb adv = ev ? spin_in[7:0] : 8'd0;
`endif
  always_ff @(posedge clk) begin
    strobe_d <= strobe;
    tog_d <= spin_in[8];
    if (reset) begin
      spin_out <= 8'd0;
      speed <= SMIN;
      cnt <= 32'd0;
      last_dir <= 2'b00;
    end else begin
      spin_out <= spin_out + dstep + adv;
      if (se) begin
        speed <= speed_nx;
        cnt <= cnt_nx;
        last_dir <= dir;
      end
    end
  end
endmodule

// File: tb/tb_spin_accumulator.sv
// tb_spin_accumulator: directed table plus hand sequences checking ramp, wrap, analog events and smoothing.
module tb_spin_accumulator;
  logic clk = 0, reset = 1, minus = 0, plus = 0, fast = 0, strobe = 0;
  logic [8:0] spin_in = 9'h000;
  logic [7:0] spin_out;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic rst, mn, pl, fs;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  spin_accumulator dut (
    .clk(clk), .reset(reset), .minus(minus), .plus(plus), .fast(fast),
    .strobe(strobe), .spin_in(spin_in), .spin_out(spin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: spin_out=%0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, m, p, f, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.mn = m; v.pl = p; v.fs = f; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
  endtask

  // one strobe rising edge; spin_out sampled at the negedge after the detecting posedge
  task automatic pulse(input logic m, p, f);
    @(negedge clk) begin minus = m; plus = p; fast = f; strobe = 1; end
    @(negedge clk) strobe = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    add(1, 0, 0, 0, 8'd0);
    add(0, 0, 1, 0, 8'd1);  add(0, 0, 1, 0, 8'd2);  add(0, 0, 1, 0, 8'd3);
    add(0, 0, 1, 0, 8'd4);  add(0, 0, 1, 0, 8'd6);  add(0, 0, 1, 0, 8'd8);
    add(0, 0, 1, 0, 8'd10); add(0, 0, 1, 0, 8'd12); add(0, 0, 1, 0, 8'd15);
    add(0, 0, 1, 0, 8'd18); add(0, 0, 1, 0, 8'd21); add(0, 0, 1, 0, 8'd24);
    add(1, 0, 0, 0, 8'd0);
    add(0, 1, 0, 0, 8'd255); add(0, 1, 0, 0, 8'd254);
    add(0, 0, 1, 1, 8'd0);   add(0, 0, 1, 1, 8'd2);   add(0, 0, 1, 1, 8'd4);
    add(0, 1, 1, 0, 8'd4);   add(0, 1, 1, 0, 8'd4);   add(0, 1, 1, 0, 8'd4);
    add(0, 1, 1, 0, 8'd4);   add(0, 1, 1, 0, 8'd4);
    add(0, 0, 0, 0, 8'd4);
    add(0, 0, 1, 0, 8'd5);   add(0, 0, 1, 0, 8'd6);

    idle(2);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else pulse(tbl[i].mn, tbl[i].pl, tbl[i].fs);
      check($sformatf("vec%0d", i), spin_out, tbl[i].exp);
    end

    // held inputs without strobe edges do not move the dial
    @(negedge clk) begin minus = 0; plus = 1; fast = 1; end
    idle(6);
    check("no_strobe_hold", spin_out, 8'd6);
    @(negedge clk) begin plus = 0; fast = 0; end

`ifndef SPIN_SMOOTH_EN
    do_reset();
    pulse(0, 1, 0);
    check("pre_analog", spin_out, 8'd1);
    @(negedge clk) spin_in = 9'h1FD;
    @(negedge clk);
    check("analog_neg3", spin_out, 8'd254);
    idle(4);
    spin_in = 9'h1FD;
    idle(2);
    check("analog_repeat", spin_out, 8'd254);
    @(negedge clk) spin_in = 9'h00C;
    @(negedge clk);
    check("analog_wrap_up", spin_out, 8'd10);
    pulse(0, 0, 0);
    check("strobe_none", spin_out, 8'd10);
    @(negedge clk) begin plus = 1; strobe = 1; spin_in = 9'h105; end
    @(negedge clk) strobe = 0;
    check("same_cycle", spin_out, 8'd16);
    @(negedge clk) begin plus = 0; spin_in = 9'h000; end
    @(negedge clk);
    check("delta_zero", spin_out, 8'd16);
`else
    do_reset();
    @(negedge clk) spin_in = 9'h114;
    idle(2);
    check("smooth_pending", spin_out, 8'd0);
    pulse(0, 0, 0); check("drain1", spin_out, 8'd8);
    pulse(0, 0, 0); check("drain2", spin_out, 8'd16);
    pulse(0, 0, 0); check("drain3", spin_out, 8'd20);
    pulse(0, 0, 0); check("drain_empty", spin_out, 8'd20);
    @(negedge clk) spin_in = 9'h014;
    pulse(0, 0, 0); check("drain_again", spin_out, 8'd28);
    do_reset();
    check("reset_mid_drain", spin_out, 8'd0);
    pulse(0, 0, 0); check("post_reset1", spin_out, 8'd0);
    pulse(0, 0, 0); check("post_reset2", spin_out, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
